// File: rtl/riscv_pkg.sv
// Shared RV64 definitions for the fetch/decode slice: widths, the canonical
// NOP, the IF/ID slot layout and the fetch-fault reason codes.
package riscv_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  // Why a fetch faulted; not driven yet, kept so later fault reporting
  // slots in without touching the package users.
  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_RANGE    = 2'd2
  } fetch_fault_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [ILEN-1:0] instr;
    logic            valid;
  } if_id_t;

  // Empty pipeline slot: NOP, not valid, PC fields cleared.
  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.pc       = '0;
    b.pc_plus4 = '0;
    b.instr    = NOP_INSTR;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: redirect/hazard controls, imem load port, IF/ID outputs.
interface if_stage_if #(
  parameter int IMEM_DEPTH = 64
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0] imem_wdata;

  logic [63:0] pc;
  logic [63:0] if_id_pc;
  logic [63:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        fetch_fault;

  modport master (
    output stall, flush, branch_taken, branch_target,
           imem_we, imem_waddr, imem_wdata,
    input  pc, if_id_pc, if_id_pc_plus4, if_id_instr, if_id_valid, fetch_fault
  );

  modport slave (
    input  stall, flush, branch_taken, branch_target,
           imem_we, imem_waddr, imem_wdata,
    output pc, if_id_pc, if_id_pc_plus4, if_id_instr, if_id_valid, fetch_fault
  );
endinterface

// File: rtl/instr_mem.sv
// Instruction memory: async read for same-cycle fetch, sync write for loading.
// Not reset; contents survive a pipeline reset.
module instr_mem #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  // Load port; a read of the same word this cycle still sees the old data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC priority, fetch legality check,
// IF/ID pipeline register and sticky fetch-fault flag.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              IMEM_DEPTH = 64
) (
  input  logic   clk,
  input  logic   reset,
  if_stage_if.slave bus
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
  if_id_t          if_id_q, if_id_d;
  logic            fault_q, fault_d;
  logic [ILEN-1:0] fetch_word;
  logic            fetch_legal;
  logic            fault_set;

  // Local +4; the datapath adder is not shared.
  assign pc_plus4 = pc_q + 64'd4;

  // Word aligned and inside the memory image.
  assign fetch_legal = (pc_q[1:0] == 2'b00) && (pc_q[XLEN-1:AW+2] == '0);

  instr_mem #(.DEPTH(IMEM_DEPTH)) u_imem (
    .clk   (clk),
    .we    (bus.imem_we),
    .waddr (bus.imem_waddr),
    .wdata (bus.imem_wdata),
    .raddr (pc_q[AW+1:2]),
    .rdata (fetch_word)
  );

  // Next-PC and IF/ID selection. The PC freezes on the same edge the fault
  // is latched, so it stays parked on the offending address.
  always_comb begin
    fault_set = !fetch_legal && !bus.branch_taken && !bus.flush && !bus.stall;
    fault_d   = fault_q | fault_set;

    pc_d = pc_plus4;
    if (fault_q || fault_set) pc_d = pc_q;
    else if (bus.branch_taken) pc_d = bus.branch_target;
    else if (bus.stall)        pc_d = pc_q;

    if_id_d = if_id_q;
    if (bus.branch_taken || bus.flush) begin
      if_id_d = if_id_bubble();
    end else if (bus.stall) begin
      if_id_d = if_id_q;
    end else if (!fetch_legal || fault_q) begin
      if_id_d = if_id_bubble();
    end else begin
      if_id_d.pc       = pc_q;
      if_id_d.pc_plus4 = pc_plus4;
      if_id_d.instr    = fetch_word;
      if_id_d.valid    = 1'b1;
    end
  end

  // State registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      if_id_q <= if_id_bubble();
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
      fault_q <= fault_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.if_id_pc       = if_id_q.pc;
  assign bus.if_id_pc_plus4 = if_id_q.pc_plus4;
  assign bus.if_id_instr    = if_id_q.instr;
  assign bus.if_id_valid    = if_id_q.valid;
  assign bus.fetch_fault    = fault_q;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: each step pushes its expected post-edge state
// into a scoreboard queue, which is popped and checked after the edge.
module tb_if_stage;
  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  if_stage_if #(.IMEM_DEPTH(DEPTH)) bus ();

  if_stage #(.RESET_PC(64'd0), .IMEM_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] pc;
    logic [63:0] ipc;
    logic [63:0] ip4;
    logic [31:0] instr;
    logic        valid;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [DEPTH];
  int          nassert = 0;
  int          nfail   = 0;

  function automatic exp_t slot(logic [63:0] pc_after, logic [63:0] ipc);
    exp_t e;
    e.pc = pc_after; e.ipc = ipc; e.ip4 = ipc + 64'd4;
    e.instr = mem_m[ipc[7:2]]; e.valid = 1'b1; e.fault = 1'b0;
    return e;
  endfunction

  function automatic exp_t bubble(logic [63:0] pc_after, logic f);
    exp_t e;
    e.pc = pc_after; e.ipc = '0; e.ip4 = '0;
    e.instr = NOP; e.valid = 1'b0; e.fault = f;
    return e;
  endfunction

  task automatic chk64(string tag, logic [63:0] obs, logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      nassert++; nfail++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk64({tag, ".pc"},      bus.pc,                     e.pc);
    chk64({tag, ".ipc"},     bus.if_id_pc,               e.ipc);
    chk64({tag, ".ip4"},     bus.if_id_pc_plus4,         e.ip4);
    chk64({tag, ".instr"},   {32'd0, bus.if_id_instr},   {32'd0, e.instr});
    chk64({tag, ".valid"},   {63'd0, bus.if_id_valid},   {63'd0, e.valid});
    chk64({tag, ".fault"},   {63'd0, bus.fetch_fault},   {63'd0, e.fault});
  endtask

  // One clock: drive controls, queue the expectation, check after the edge.
  task automatic step(string tag, logic rs, logic st, logic fl, logic br,
                      logic [63:0] tgt, exp_t e);
    reset = rs;
    bus.stall = st; bus.flush = fl; bus.branch_taken = br; bus.branch_target = tgt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    bus.stall = 0; bus.flush = 0; bus.branch_taken = 0; bus.branch_target = '0;
    bus.imem_we = 0; bus.imem_waddr = '0; bus.imem_wdata = '0;

    // Preload memory while held in reset.
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] w;
      case (i)
        0: w = 32'h0030_0313;
        1: w = 32'h0030_8233;
        2: w = 32'hFE10_8EE3;
        3: w = 32'h0010_0E63;
        default: w = 32'hA500_0000 | 32'(i);
      endcase
      bus.imem_we = 1'b1; bus.imem_waddr = 6'(i); bus.imem_wdata = w;
      mem_m[i] = w;
      @(posedge clk); #1;
    end
    bus.imem_we = 1'b0;

    step("reset",   1, 0, 0, 0, 0, bubble(0, 0));

    // Sequential fetch.
    step("seq0",    0, 0, 0, 0, 0, slot(4, 0));
    step("seq1",    0, 0, 0, 0, 0, slot(8, 4));
    step("seq2",    0, 0, 0, 0, 0, slot(12, 8));
    step("seq3",    0, 0, 0, 0, 0, slot(16, 12));

    // Get to PC=8 with IF/ID holding PC=4, then stall two cycles.
    step("br4",     0, 0, 0, 1, 4, bubble(4, 0));
    step("fetch4",  0, 0, 0, 0, 0, slot(8, 4));
    step("stall0",  0, 1, 0, 0, 0, slot(8, 4));
    step("stall1",  0, 1, 0, 0, 0, slot(8, 4));
    step("resume",  0, 0, 0, 0, 0, slot(12, 8));

    // Redirect at PC=12, then the same with stall asserted alongside.
    step("redir",   0, 0, 0, 1, 4, bubble(4, 0));
    step("redir_t", 0, 0, 0, 0, 0, slot(8, 4));
    step("to12",    0, 0, 0, 0, 0, slot(12, 8));
    step("redir_s", 0, 1, 0, 1, 4, bubble(4, 0));
    step("redir_st",0, 0, 0, 0, 0, slot(8, 4));

    // Flush alone at PC=8: PC still advances.
    step("flush",   0, 0, 1, 0, 0, bubble(12, 0));
    step("flush_n", 0, 0, 0, 0, 0, slot(16, 12));

    // Write the word being fetched: IF/ID gets the old word.
    bus.imem_we = 1'b1; bus.imem_waddr = 6'd4; bus.imem_wdata = 32'h1234_5678;
    step("wr_old",  0, 0, 0, 0, 0, slot(20, 16));
    mem_m[4] = 32'h1234_5678;
    bus.imem_we = 1'b0;
    step("br16",    0, 0, 0, 1, 16, bubble(16, 0));
    step("wr_new",  0, 0, 0, 0, 0, slot(20, 16));

    // Misaligned target.
    step("mis_br",  0, 0, 0, 1, 6, bubble(6, 0));
    step("mis_flt", 0, 0, 0, 0, 0, bubble(6, 1));
    step("mis_hold",0, 0, 0, 1, 4, bubble(6, 1));
    step("mis_fl",  0, 0, 1, 0, 0, bubble(6, 1));
    step("mis_rst", 1, 0, 0, 0, 0, bubble(0, 0));
    step("mis_rs0", 0, 0, 0, 0, 0, slot(4, 0));

    // Out-of-range target.
    step("rng_br",  0, 0, 0, 1, 256, bubble(256, 0));
    step("rng_flt", 0, 0, 0, 0, 0, bubble(256, 1));
    step("rng_hold",0, 0, 0, 0, 0, bubble(256, 1));
    step("rng_rst", 1, 0, 0, 0, 0, bubble(0, 0));
    step("rng_rs0", 0, 0, 0, 0, 0, slot(4, 0));

    // Last legal word, then running off the end.
    step("top_br",  0, 0, 0, 1, 252, bubble(252, 0));
    step("top_w",   0, 0, 0, 0, 0, slot(256, 252));
    step("top_flt", 0, 0, 0, 0, 0, bubble(256, 1));

    // Reset during a redirect discards the redirect and clears the fault.
    step("rst_br",  1, 0, 0, 1, 8, bubble(0, 0));
    step("rst_br1", 0, 0, 0, 0, 0, slot(4, 0));
    step("rst_br2", 0, 0, 0, 0, 0, slot(8, 4));

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage with PC register, on-chip instruction memory and IF/ID pipeline register. It sits directly upstream of the decode/execute datapath: `reg_file`, `imm_generate`, `control`, `bit_64`, `branch_pc` and `MEM`. It supplies one 32-bit instruction per cycle with its PC and PC+4. It also accepts redirects from the branch resolution logic (`branch_pc` target plus ALU `zero`) and stall/flush requests from hazard logic.

## Interface
- `RESET_PC`, 64'd0: PC value loaded on reset.
- `IMEM_DEPTH`, 64: instruction memory size in 32-bit words; power of two, ≥ 2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold PC and IF/ID register.
- `flush`  in  1  replace IF/ID contents with a bubble.
- `branch_taken`  in  1  redirect PC to `branch_target`.
- `branch_target`  in  64  redirect address (byte address).
- `imem_we`  in  1  instruction-memory load strobe.
- `imem_waddr`  in  log2(IMEM_DEPTH)  word address for load.
- `imem_wdata`  in  32  instruction word to load.
- `pc`  out  64  current fetch PC.
- `if_id_pc`  out  64  PC of latched instruction.
- `if_id_pc_plus4`  out  64  `if_id_pc` + 4.
- `if_id_instr`  out  32  latched instruction.
- `if_id_valid`  out  1  latched slot holds a real instruction.
- `fetch_fault`  out  1  sticky: misaligned or out-of-range fetch occurred.

## Operation
- Reset (when `reset`=1 at an edge):
  - `pc`=RESET_PC.
  - `if_id_pc`=0, `if_id_pc_plus4`=0.
  - `if_id_instr`=NOP (32'h00000013), `if_id_valid`=0.
  - `fetch_fault`=0.
  - Memory contents are not cleared.
- Fetch address legality:
  - Legal when `pc[1:0]`=0 and `pc` < 4·IMEM_DEPTH.
  - Read is combinational from word `pc[log2(IMEM_DEPTH)+1:2]`.
- Next-PC priority:
  1. reset
  2. `fetch_fault` set: hold
  3. `branch_taken`: `branch_target`
  4. `stall`: hold
  5. otherwise `pc`+4, modulo 2^64 (wraps silently).
- IF/ID update priority:
  1. reset
  2. `branch_taken` or `flush`: bubble (NOP, valid=0, pc fields 0)
  3. `stall`: hold all four fields
  4. illegal fetch address: bubble, and set `fetch_fault`
  5. otherwise load `pc`, `pc`+4, memory word, valid=1.
- `branch_taken` together with `stall`: the redirect wins. PC takes the target and IF/ID takes a bubble, so no fetched instruction is lost or duplicated.
- `flush` without `branch_taken`: PC still advances (or holds if `stall`=1).
- `fetch_fault` is cleared only by reset. Once it is set, PC freezes and IF/ID emits bubbles until reset, unless `branch_taken` or `flush` forces a bubble anyway.
- Memory write: on the edge when `imem_we`=1, `mem[imem_waddr]`=`imem_wdata`. A write to the word being fetched in the same cycle makes IF/ID latch the old word.
- `branch_target` with `[1:0]`≠0 is accepted into PC. It faults on the following fetch.

## Timing
- Fetch latency is 1 cycle: the instruction at `pc` during cycle n appears on `if_id_*` after edge n.
- Throughput is one instruction per cycle when there is no stall, redirect or fault.
- Redirect penalty is 1 bubble. If `branch_taken` is high at edge k, then `pc`=target after k, `if_id_valid`=0 after k, and the target instruction is valid after k+1.
- Reset release: the first valid IF/ID slot (instruction at RESET_PC) appears after the first edge with `reset`=0.
- Reset asserted mid-stall or mid-redirect overrides everything on that edge.
- `fetch_fault` rises on the same edge that latches the faulting bubble.
- All outputs are registered except `pc`, which is the register itself. No combinational path from any input to any output.

## Structure
- Shared package `riscv_pkg` holds:
  - XLEN=64, ILEN=32
  - NOP_INSTR=32'h00000013
  - fetch-fault reason encoding, reserved for later use.
- One sub-module, `instr_mem`:
  - array of IMEM_DEPTH × 32 bits
  - combinational read port
  - synchronous write port.
- Top level holds the PC register, next-PC priority mux, legality check, IF/ID register and fault flag.
- Adder for PC+4 is local; it does not share the datapath `adder`.

## Test plan
- Sequential fetch:
  - Stimulus: load words 0..3 with 0x00300313, 0x00308233, 0xFE108EE3, 0x00100E63; RESET_PC=0; release reset; run 4 edges.
  - Required: `if_id_instr` shows those words in order with `if_id_pc`=0,4,8,12, `if_id_pc_plus4`=4,8,12,16, valid=1.
- Stall:
  - Stimulus: assert `stall` for 2 cycles at PC=8.
  - Required: `pc` stays 8 and IF/ID holds PC=4 for both cycles; resume fetches PC=8 next, with no duplicate and no skip.
- Branch redirect:
  - Stimulus: `branch_taken`=1 with target=4 at PC=12.
  - Required: next edge gives `pc`=4 and `if_id_valid`=0; following edge gives `if_id_pc`=4.
  - Repeat with `stall`=1 at the same time; the result must be identical.
- Flush alone:
  - Stimulus: `flush`=1 at PC=8.
  - Required: IF/ID=NOP with valid=0, `pc`=12; next slot is the instruction at 12.
- Faults:
  - Stimulus: branch to 6.
  - Required: one edge later IF/ID shows a bubble at PC=6; on the following edge `fetch_fault`=1, `pc` frozen at 6, bubbles continue.
  - Stimulus: branch to 4·IMEM_DEPTH (256).
  - Required: same fault behaviour.
  - Required in both cases: reset clears the fault and restarts at RESET_PC.
- Reset mid-operation: assert `reset` during a redirect. Required: `pc`=RESET_PC, valid=0, fault=0, and the redirect is discarded.
